buck_pwm_ctrl: RTL
==================

Name: buck_pwm_ctrl

Overview:
Digital switching controller for the synchronous buck power stage. It turns a duty command into non-overlapping high-side/low-side gate signals with fixed dead time, soft-start ramp, cycle-by-cycle overcurrent limit and diode emulation (low-side cut at zero crossing). It sits between the emulated regulation logic and the buck stage's hs/ls inputs, and samples inductor current as a signed fixed-point integer.

Parameters:
PERIOD, 20, switching period in clk cycles (≥ 2*DEAD+2)
DEAD, 2, dead-time length in clk cycles (≥1)
CNT_W, 8, width of period/duty counters (2^CNT_W > PERIOD)
SS_STEP, 2, soft-start duty increment per period in cycles (≥1)
I_W, 16, width of signed inductor-current sample
OC_LIMIT, 16'sd20000, overcurrent threshold, signed I_W
ZC_THRESH, 16'sd10, zero-crossing threshold, signed I_W

Ports:
clk  in  1  controller clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run request; low forces IDLE
duty_cmd  in  CNT_W  requested high-side on-time in cycles
i_ind  in  I_W  signed inductor-current sample
hs  out  1  high-side gate
ls  out  1  low-side gate
period_start  out  1  one-cycle pulse in cycle cnt==0
oc_event  out  1  one-cycle pulse when overcurrent cuts hs
zc_event  out  1  one-cycle pulse when zero-crossing cuts/blocks ls
duty_eff  out  CNT_W  duty in force this period

Behaviour:
- Reset (rst_n low, async): state=IDLE, cnt=0, dead counter=0, duty_eff=0, hs=ls=period_start=oc_event=zc_event=0. All outputs decoded from registers; no combinational path from inputs to outputs.
- States: IDLE, HS, DT1, LS, DT2. hs=1 only in HS; ls=1 only in LS; hs&ls never both 1.
- DMAX = PERIOD-2*DEAD. dclamp = min(duty_cmd, DMAX).
- Period start (edge leaving IDLE with enable=1, or edge with cnt==PERIOD-1 and enable=1): cnt←0; duty_eff←0+SS_STEP clipped to dclamp when leaving IDLE, else min(duty_eff+SS_STEP, dclamp); if dclamp<duty_eff, duty_eff←dclamp immediately. Next state HS if new duty_eff>0, else DT1. duty_cmd sampled only at period start.
- cnt increments every cycle while not IDLE, wraps PERIOD-1→0.
- HS→DT1 on edge where cnt==duty_eff-1, or earlier on any edge where signed i_ind ≥ OC_LIMIT (oc_event=1 in next cycle only). No re-entry to HS before next period.
- DT1 lasts exactly DEAD cycles. On exit: if signed i_ind ≤ ZC_THRESH → DT2 with zc_event pulse; else if cnt+1 < PERIOD-DEAD → LS; else DT2.
- LS→DT2 on edge where cnt==PERIOD-DEAD-1, or where signed i_ind ≤ ZC_THRESH (zc_event pulse next cycle). LS not re-entered this period.
- DT2 holds until period wrap.
- period_start=1 exactly in cycles where cnt==0 and state≠IDLE.
- enable low sampled on any edge: next cycle IDLE, hs=ls=0, cnt=0, duty_eff=0; re-enable restarts soft start from 0.
- Simultaneous OC and HS end-of-on-time: single transition to DT1, oc_event still pulses.
- duty_cmd=0: duty_eff=0, hs never high, DT1 still precedes LS.

Test Plan:
- Soft start: defaults, duty_cmd=8, i_ind=1000 constant, enable rises → duty_eff=2,4,6,8,8 in periods 1-5; hs high 2,4,6,8,8 consecutive cycles from each period_start.
- Steady state: duty_eff=8, i_ind=1000 → hs at cnt 0-7, both low cnt 8-9, ls at cnt 10-17, both low cnt 18-19; hs&ls never 1.
- Diode emulation: steady state, i_ind=5 during cnt 13 → ls low from cnt 14, zc_event=1 at cnt 14 only, ls stays low to cnt 19, normal next period with i_ind=1000.
- Overcurrent: steady state, i_ind=20000 at cnt 3 → hs low from cnt 4, oc_event pulse at cnt 4, ls high cnt 6-17 (i_ind back to 1000).
- Clamp: duty_cmd=19 after soft start → duty_eff=16, hs cnt 0-15, DT1 cnt 16-17, ls never high, DT2 cnt 18-19.
- Reset/disable: rst_n low during LS → hs=ls=0 same cycle; enable low mid-HS → IDLE next cycle, re-enable gives duty_eff=2 in first period.

Source files
------------

// File: rtl/buck_pwm_ctrl.sv
// rtl/buck_pwm_ctrl.sv - synchronous buck PWM controller with dead time,
// soft start, cycle-by-cycle overcurrent limit and diode emulation.
module buck_pwm_ctrl #(
  parameter int                     PERIOD    = 20,
  parameter int                     DEAD      = 2,
  parameter int                     CNT_W     = 8,
  parameter int                     SS_STEP   = 2,
  parameter int                     I_W       = 16,
  parameter logic signed [I_W-1:0]  OC_LIMIT  = 16'sd20000,
  parameter logic signed [I_W-1:0]  ZC_THRESH = 16'sd10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] duty_cmd,
  input  logic [I_W-1:0]   i_ind,
  output logic             hs,
  output logic             ls,
  output logic             period_start,
  output logic             oc_event,
  output logic             zc_event,
  output logic [CNT_W-1:0] duty_eff
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HS,
    S_DT1,
    S_LS,
    S_DT2
  } state_t;

  localparam logic [CNT_W-1:0] DMAX_C    = CNT_W'(PERIOD - 2 * DEAD);
  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] LS_END_C  = CNT_W'(PERIOD - DEAD - 1);
  localparam logic [CNT_W-1:0] DT_LAST_C = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] SS_C      = CNT_W'(SS_STEP);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dt_q, dt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             oc_q, oc_d;
  logic             zc_q, zc_d;

  logic [CNT_W-1:0] dclamp;
  logic [CNT_W:0]   duty_sum;
  logic [CNT_W-1:0] duty_next;
  logic             oc_hit;
  logic             zc_hit;

  // Ramp by SS_STEP toward the clamped command; a lower command takes effect at once.
  always_comb begin
    dclamp    = (duty_cmd > DMAX_C) ? DMAX_C : duty_cmd;
    duty_sum  = {1'b0, duty_q} + {1'b0, SS_C};
    duty_next = (duty_sum > {1'b0, dclamp}) ? dclamp : duty_sum[CNT_W-1:0];
    oc_hit    = ($signed(i_ind) >= OC_LIMIT);
    zc_hit    = ($signed(i_ind) <= ZC_THRESH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE_C;
    dt_d    = dt_q;
    duty_d  = duty_q;
    oc_d    = 1'b0;
    zc_d    = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      dt_d    = '0;
      duty_d  = '0;
    end else if (state_q == S_IDLE || cnt_q == LAST_C) begin
      cnt_d   = '0;
      dt_d    = '0;
      duty_d  = duty_next;
      state_d = (duty_next != '0) ? S_HS : S_DT1;
    end else begin
      unique case (state_q)
        S_HS: begin
          oc_d = oc_hit;
          if (oc_hit || cnt_q == duty_q - ONE_C) begin
            state_d = S_DT1;
            dt_d    = '0;
          end
        end
        S_DT1: begin
          if (dt_q == DT_LAST_C) begin
            if (zc_hit) begin
              state_d = S_DT2;
              zc_d    = 1'b1;
            end else if (cnt_q < LS_END_C) begin
              state_d = S_LS;
            end else begin
              state_d = S_DT2;
            end
          end else begin
            dt_d = dt_q + ONE_C;
          end
        end
        S_LS: begin
          if (zc_hit) begin
            state_d = S_DT2;
            zc_d    = 1'b1;
          end else if (cnt_q == LS_END_C) begin
            state_d = S_DT2;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dt_q    <= '0;
      duty_q  <= '0;
      oc_q    <= 1'b0;
      zc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dt_q    <= dt_d;
      duty_q  <= duty_d;
      oc_q    <= oc_d;
      zc_q    <= zc_d;
    end
  end

  assign hs           = (state_q == S_HS);
  assign ls           = (state_q == S_LS);
  assign period_start = (state_q != S_IDLE) && (cnt_q == '0);
  assign oc_event     = oc_q;
  assign zc_event     = zc_q;
  assign duty_eff     = duty_q;

endmodule
